// File: rtl/except_unit_if.sv
// MEM-stage exception/CP0 bundle between the pipeline (master) and except_unit (slave).
// Carries the MEM instruction flags, the pending CP0 write, CP0 read-back values and the redirect outputs.
interface except_unit_if;
  logic        mem_valid_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic        mem_cp0_we_i;
  logic [4:0]  mem_cp0_waddr_i;
  logic [31:0] mem_cp0_data_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_o;
  logic [4:0]  wb_cp0_waddr_o;
  logic [31:0] wb_cp0_data_o;
  logic [31:0] excepttype_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] epc_o;
  logic [15:0] except_cnt_o;

  modport slave (
    input  mem_valid_i, excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    input  mem_cp0_we_i, mem_cp0_waddr_i, mem_cp0_data_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_o, wb_cp0_waddr_o, wb_cp0_data_o,
    output excepttype_o, flush_o, new_pc_o, epc_o, except_cnt_o
  );

  modport master (
    output mem_valid_i, excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    output mem_cp0_we_i, mem_cp0_waddr_i, mem_cp0_data_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_o, wb_cp0_waddr_o, wb_cp0_data_o,
    input  excepttype_o, flush_o, new_pc_o, epc_o, except_cnt_o
  );
endinterface

// File: rtl/except_unit.sv
// MEM-stage exception resolver: combinational code/flush/redirect, one-cycle FLUSH state, WB CP0-write latch.
// Optional taken-exception counter is built only when EXCEPT_CNT_EN is defined.
module except_unit (
  input logic          clk,
  input logic          rst,
  except_unit_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state_q, state_d;
  logic        wb_we_q;
  logic [4:0]  wb_waddr_q;
  logic [31:0] wb_data_q;
  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_pending;
  logic        taken;
  logic [31:0] code;
  logic [31:0] new_pc;

  // The WB latch has not reached CP0 yet, so its value overrides the committed registers.
  always_comb begin
    eff_status = bus.cp0_status_i;
    eff_cause  = bus.cp0_cause_i;
    eff_epc    = bus.cp0_epc_i;
    if (wb_we_q) begin
      case (wb_waddr_q)
        5'd12: eff_status = wb_data_q;
        5'd13: begin
          eff_cause[9:8]   = wb_data_q[9:8];
          eff_cause[23:22] = wb_data_q[23:22];
        end
        5'd14: eff_epc = wb_data_q;
        default: ;
      endcase
    end
  end

  assign int_pending = (|(eff_cause[15:8] & eff_status[15:8])) && eff_status[0] && !eff_status[1];

  always_comb begin
    state_d = state_q;
    code    = 32'h0;
    new_pc  = 32'h0;
    taken   = 1'b0;
    if (rst && state_q == IDLE && bus.mem_valid_i) begin
      if (int_pending)               code = 32'h1;
      else if (bus.excepttype_i[8])  code = 32'h8;
      else if (bus.excepttype_i[9])  code = 32'ha;
      else if (bus.excepttype_i[10]) code = 32'hd;
      else if (bus.excepttype_i[11]) code = 32'hc;
      else if (bus.excepttype_i[12]) code = 32'he;
    end
    taken = (code != 32'h0);
    if (taken) new_pc = (code == 32'he) ? eff_epc : 32'h0000_0020;
    if (state_q == IDLE) begin
      if (taken) state_d = FLUSH;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A taken exception squashes its own CP0 write; FLUSH squashes whatever follows it.
  always_ff @(posedge clk) begin
    if (!rst || state_q == FLUSH || taken || !bus.mem_valid_i) begin
      wb_we_q    <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_data_q  <= 32'h0;
    end else begin
      wb_we_q    <= bus.mem_cp0_we_i;
      wb_waddr_q <= bus.mem_cp0_waddr_i;
      wb_data_q  <= bus.mem_cp0_data_i;
    end
  end

`ifdef EXCEPT_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst)                            cnt_q <= 16'h0;
    else if (taken && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h1;
  end
  assign bus.except_cnt_o = cnt_q;
`else
  assign bus.except_cnt_o = 16'h0;
`endif

  assign bus.excepttype_o   = code;
  assign bus.flush_o        = taken;
  assign bus.new_pc_o       = new_pc;
  assign bus.epc_o          = eff_epc;
  assign bus.wb_cp0_we_o    = wb_we_q;
  assign bus.wb_cp0_waddr_o = wb_waddr_q;
  assign bus.wb_cp0_data_o  = wb_data_q;

  logic unused_bits;
  assign unused_bits = ^{bus.excepttype_i[31:13], bus.excepttype_i[7:0], bus.current_inst_addr_i,
                         bus.is_in_delayslot_i, eff_status[31:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0]};
endmodule

// File: tb/tb_except_unit.sv
// Bench for except_unit: directed vector table, reset/counter sequences, then random stimulus vs a model.
module tb_except_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  except_unit_if bus();
  except_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] exc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [31:0] status, cause, epc;
    logic [31:0] e_code, e_pc, e_epc;
    logic        e_we;
  } vec_t;

  vec_t tbl[32];

  // reference model state
  bit          m_flush;
  bit          m_we;
  bit [4:0]    m_waddr;
  bit [31:0]   m_data;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] exc, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] st, input logic [31:0] ca,
                       input logic [31:0] ep);
    bus.mem_valid_i         = v;
    bus.excepttype_i        = exc;
    bus.current_inst_addr_i = 32'h80;
    bus.is_in_delayslot_i   = 1'b0;
    bus.mem_cp0_we_i        = we;
    bus.mem_cp0_waddr_i     = wa;
    bus.mem_cp0_data_i      = wd;
    bus.cp0_status_i        = st;
    bus.cp0_cause_i         = ca;
    bus.cp0_epc_i           = ep;
  endtask

  function automatic vec_t mk(logic v, logic [31:0] exc, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] st, logic [31:0] ca, logic [31:0] ep,
                              logic [31:0] e_code, logic [31:0] e_pc, logic [31:0] e_epc, logic e_we);
    vec_t r;
    r.valid = v; r.exc = exc; r.we = we; r.waddr = wa; r.data = wd;
    r.status = st; r.cause = ca; r.epc = ep;
    r.e_code = e_code; r.e_pc = e_pc; r.e_epc = e_epc; r.e_we = e_we;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // Model: effective CP0 values, then the first matching cause in priority order.
  function automatic bit [31:0] model_eff_epc();
    if (m_we && m_waddr == 5'd14) return m_data;
    return bus.cp0_epc_i;
  endfunction

  function automatic bit [31:0] model_code();
    bit [31:0] st, ca;
    bit [31:0] mask;
    int        bits[5]  = '{8, 9, 10, 11, 12};
    bit [31:0] codes[5] = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};
    if (!rst || m_flush || !bus.mem_valid_i) return 0;
    st = bus.cp0_status_i;
    ca = bus.cp0_cause_i;
    mask = 32'h00C0_0300;
    if (m_we && m_waddr == 5'd12) st = m_data;
    if (m_we && m_waddr == 5'd13) ca = (ca & ~mask) | (m_data & mask);
    if ((((ca >> 8) & (st >> 8) & 32'hFF) != 0) && (st % 2 == 1) && ((st >> 1) % 2 == 0)) return 32'h1;
    for (int i = 0; i < 5; i++)
      if (((bus.excepttype_i >> bits[i]) & 1) == 1) return codes[i];
    return 0;
  endfunction

  task automatic model_step(input bit [31:0] code);
    if (!rst) begin
      m_flush = 0; m_we = 0; m_waddr = 0; m_data = 0; m_cnt = 0;
    end else if (m_flush) begin
      m_flush = 0; m_we = 0; m_waddr = 0; m_data = 0;
    end else if (code != 0) begin
      m_flush = 1; m_we = 0; m_waddr = 0; m_data = 0;
`ifdef EXCEPT_CNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end else if (bus.mem_valid_i) begin
      m_we = bus.mem_cp0_we_i; m_waddr = bus.mem_cp0_waddr_i; m_data = bus.mem_cp0_data_i;
    end else begin
      m_we = 0; m_waddr = 0; m_data = 0;
    end
  endtask

  initial begin
    // valid exc we wa data status cause epc | code newpc epc we
    tbl[0]  = mk(1, 32'h100,  0, 0,  0,          0,      0,     0,      32'h8, 32'h20,   0,       0);
    tbl[1]  = mk(1, 32'h100,  0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[2]  = mk(1, 0,        1, 14, 32'h1234,   0,      0,     0,      0,     0,        0,       0);
    tbl[3]  = mk(1, 32'h1000, 0, 0,  0,          0,      0,     0,      32'he, 32'h1234, 32'h1234, 1);
    tbl[4]  = mk(1, 32'h1000, 0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[5]  = mk(1, 32'h100,  0, 0,  0,          32'hFF01, 32'h400, 0,  32'h1, 32'h20,   0,       0);
    tbl[6]  = mk(1, 32'h100,  0, 0,  0,          32'hFF01, 32'h400, 0,  0,     0,        0,       0);
    tbl[7]  = mk(1, 32'h100,  0, 0,  0,          32'hFF03, 32'h400, 0,  32'h8, 32'h20,   0,       0);
    tbl[8]  = mk(1, 32'h100,  0, 0,  0,          32'hFF03, 32'h400, 0,  0,     0,        0,       0);
    tbl[9]  = mk(1, 32'h800,  1, 12, 32'h1,      0,      0,     0,      32'hc, 32'h20,   0,       0);
    tbl[10] = mk(0, 0,        0, 0,  0,          32'hFF01, 32'h400, 0,  0,     0,        0,       0);
    tbl[11] = mk(0, 0,        0, 0,  0,          32'hFF01, 32'h400, 0,  0,     0,        0,       0);
    tbl[12] = mk(1, 32'h200,  0, 0,  0,          0,      0,     0,      32'ha, 32'h20,   0,       0);
    tbl[13] = mk(1, 32'h200,  0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[14] = mk(1, 32'h400,  0, 0,  0,          0,      0,     0,      32'hd, 32'h20,   0,       0);
    tbl[15] = mk(1, 32'h400,  0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[16] = mk(1, 32'h600,  0, 0,  0,          0,      0,     0,      32'ha, 32'h20,   0,       0);
    tbl[17] = mk(1, 32'h600,  0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[18] = mk(1, 32'hC00,  0, 0,  0,          0,      0,     0,      32'hd, 32'h20,   0,       0);
    tbl[19] = mk(1, 32'hC00,  0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[20] = mk(1, 32'h1800, 0, 0,  0,          0,      0,     0,      32'hc, 32'h20,   0,       0);
    tbl[21] = mk(1, 32'h1800, 0, 0,  0,          0,      0,     0,      0,     0,        0,       0);
    tbl[22] = mk(1, 32'h1000, 0, 0,  0,          0,      0,     32'h5550, 32'he, 32'h5550, 32'h5550, 0);
    tbl[23] = mk(1, 32'h1000, 0, 0,  0,          0,      0,     32'h5550, 0,   0,        32'h5550, 0);
    tbl[24] = mk(1, 0,        1, 13, 32'h300,    32'h301, 0,    0,      0,     0,        0,       0);
    tbl[25] = mk(1, 0,        0, 0,  0,          32'h301, 0,    0,      32'h1, 32'h20,   0,       1);
    tbl[26] = mk(1, 0,        0, 0,  0,          32'h301, 0,    0,      0,     0,        0,       0);
    tbl[27] = mk(1, 0,        1, 13, 32'h400,    32'hFF01, 0,   0,      0,     0,        0,       0);
    tbl[28] = mk(1, 0,        0, 0,  0,          32'hFF01, 0,   0,      0,     0,        0,       1);
    tbl[29] = mk(1, 0,        1, 12, 32'hFF01,   0,      32'h400, 0,    0,     0,        0,       0);
    tbl[30] = mk(1, 0,        0, 0,  0,          0,      32'h400, 0,    32'h1, 32'h20,   0,       1);
    tbl[31] = mk(1, 0,        0, 0,  0,          0,      32'h400, 0,    0,     0,        0,       0);

    do_reset();
    chk("reset_wb_we", {31'h0, bus.wb_cp0_we_o}, 0);
    chk("reset_wb_waddr", {27'h0, bus.wb_cp0_waddr_o}, 0);
    chk("reset_wb_data", bus.wb_cp0_data_o, 0);
    chk("reset_cnt", {16'h0, bus.except_cnt_o}, 0);

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].valid, tbl[i].exc, tbl[i].we, tbl[i].waddr, tbl[i].data,
            tbl[i].status, tbl[i].cause, tbl[i].epc);
      #4;
      chk($sformatf("tbl%0d_code", i), bus.excepttype_o, tbl[i].e_code);
      chk($sformatf("tbl%0d_flush", i), {31'h0, bus.flush_o}, {31'h0, tbl[i].e_code != 0});
      chk($sformatf("tbl%0d_newpc", i), bus.new_pc_o, tbl[i].e_pc);
      chk($sformatf("tbl%0d_epc", i), bus.epc_o, tbl[i].e_epc);
      chk($sformatf("tbl%0d_wb_we", i), {31'h0, bus.wb_cp0_we_o}, {31'h0, tbl[i].e_we});
      next_cycle();
    end

    // reset asserted during FLUSH, and reset masking a live exception
    do_reset();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    #4 chk("rstseq_take", bus.excepttype_o, 32'h8);
    next_cycle();
    rst = 1'b0;
    #4 chk("rstseq_flush_code", bus.excepttype_o, 0);
    chk("rstseq_flush_flag", {31'h0, bus.flush_o}, 0);
    next_cycle();
    rst = 1'b1;
    #4 chk("rstseq_idle_again", bus.excepttype_o, 32'h8);
    rst = 1'b0;
    #1 chk("rstseq_masked_code", bus.excepttype_o, 0);
    chk("rstseq_masked_flush", {31'h0, bus.flush_o}, 0);
    next_cycle();
    rst = 1'b1;

`ifdef EXCEPT_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    #4 chk("cnt_three", {16'h0, bus.except_cnt_o}, 3);
    next_cycle();
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h800, 0, 0, 0, 0, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #4 chk($sformatf("cnt_sat%0d", i), {16'h0, bus.except_cnt_o}, 32'hFFFF);
      next_cycle();
    end
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    #4 chk("cnt_reset", {16'h0, bus.except_cnt_o}, 0);
    next_cycle();
`endif

    // random stimulus against the model
    do_reset();
    m_flush = 0; m_we = 0; m_waddr = 0; m_data = 0; m_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      logic [31:0] exc, wd, st, ca, code;
      logic [4:0]  wa;
      exc = 0;
      for (int b = 8; b <= 12; b++)
        if ($urandom_range(0, 5) == 0) exc[b] = 1'b1;
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) wd[1:0] = 2'b01;
      st = $urandom;
      if ($urandom_range(0, 1) == 1) st[1:0] = 2'b01;
      ca = $urandom & ($urandom_range(0, 1) == 1 ? 32'hFFFF_00FF : 32'hFFFF_FFFF);
      case ($urandom_range(0, 3))
        0: wa = 5'd12;
        1: wa = 5'd13;
        2: wa = 5'd14;
        default: wa = 5'($urandom_range(0, 31));
      endcase
      rst = ($urandom_range(0, 39) != 0);
      drive($urandom_range(0, 3) != 0, exc, 1'($urandom_range(0, 1)), wa, wd, st, ca, $urandom);
      #4;
      code = model_code();
      chk("rnd_code", bus.excepttype_o, code);
      chk("rnd_flush", {31'h0, bus.flush_o}, {31'h0, code != 0});
      chk("rnd_newpc", bus.new_pc_o, (code == 0) ? 32'h0 : (code == 32'he) ? model_eff_epc() : 32'h20);
      chk("rnd_epc", bus.epc_o, model_eff_epc());
      chk("rnd_wb_we", {31'h0, bus.wb_cp0_we_o}, {31'h0, m_we});
      if (m_we) begin
        chk("rnd_wb_waddr", {27'h0, bus.wb_cp0_waddr_o}, {27'h0, m_waddr});
        chk("rnd_wb_data", bus.wb_cp0_data_o, m_data);
      end
      chk("rnd_cnt", {16'h0, bus.except_cnt_o}, m_cnt);
      model_step(code);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
